// File: rtl/risk_arbiter_upstream.sv
// Risk-check sequencer: arbitrates NREQ order sources and one config source onto
// the single CPU port of the upstream risk cache, one transaction at a time.
module risk_arbiter_upstream #(
  parameter int NREQ     = 4,
  parameter int CLIENT_W = 10,
  parameter int TIMEOUT  = 64
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic [NREQ-1:0]          ord_valid_i,
  input  logic [NREQ*CLIENT_W-1:0] ord_client_i,
  input  logic [NREQ*16-1:0]       ord_qty_i,
  output logic [NREQ-1:0]          ord_ready_o,
  input  logic                     cfg_valid_i,
  input  logic [CLIENT_W-1:0]      cfg_client_i,
  input  logic [15:0]              cfg_max_i,
  output logic                     cfg_ready_o,
  output logic                     res_valid_o,
  input  logic                     res_ready_i,
  output logic [3:0]               res_src_o,
  output logic                     res_accept_o,
  output logic                     res_err_o,
  output logic                     cpu_req_valid_o,
  output logic                     cpu_req_rw_o,
  output logic [31:0]              cpu_req_addr_o,
  output logic [31:0]              cpu_req_data_o,
  input  logic                     cpu_res_ready_i,
  input  logic [31:0]              cpu_res_data_i,
  output logic [15:0]              acc_cnt_o,
  output logic [15:0]              rej_cnt_o
);

  localparam int RRW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TW  = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_CHECK, S_WR, S_RESP} state_t;

  state_t                state_q, state_d;
  logic [RRW-1:0]        rr_q, rr_d;
  logic                  last_cfg_q, last_cfg_d;
  logic                  is_cfg_q, is_cfg_d;
  logic [CLIENT_W-1:0]   client_q, client_d;
  logic [15:0]           qty_q, qty_d;
  logic [15:0]           max_q, max_d;
  logic [3:0]            src_q, src_d;
  logic [31:0]           rdata_q, rdata_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic                  accept_q, accept_d;
  logic                  err_q, err_d;
  logic [15:0]           acc_cnt_q, acc_cnt_d;
  logic [15:0]           rej_cnt_q, rej_cnt_d;

  logic [16:0]           sum;
  logic                  found;
  int unsigned           gidx;
  int unsigned           idx;

  // 17-bit sum so a saturated accumulator can never wrap into an accept
  assign sum = {1'b0, rdata_q[15:0]} + {1'b0, qty_q};

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q    <= S_IDLE;
      rr_q       <= '0;
      last_cfg_q <= 1'b0;
      is_cfg_q   <= 1'b0;
      client_q   <= '0;
      qty_q      <= '0;
      max_q      <= '0;
      src_q      <= '0;
      rdata_q    <= '0;
      tmo_q      <= '0;
      accept_q   <= 1'b0;
      err_q      <= 1'b0;
      acc_cnt_q  <= '0;
      rej_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      last_cfg_q <= last_cfg_d;
      is_cfg_q   <= is_cfg_d;
      client_q   <= client_d;
      qty_q      <= qty_d;
      max_q      <= max_d;
      src_q      <= src_d;
      rdata_q    <= rdata_d;
      tmo_q      <= tmo_d;
      accept_q   <= accept_d;
      err_q      <= err_d;
      acc_cnt_q  <= acc_cnt_d;
      rej_cnt_q  <= rej_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    last_cfg_d  = last_cfg_q;
    is_cfg_d    = is_cfg_q;
    client_d    = client_q;
    qty_d       = qty_q;
    max_d       = max_q;
    src_d       = src_q;
    rdata_d     = rdata_q;
    tmo_d       = tmo_q;
    accept_d    = accept_q;
    err_d       = err_q;
    acc_cnt_d   = acc_cnt_q;
    rej_cnt_d   = rej_cnt_q;
    ord_ready_o = '0;
    cfg_ready_o = 1'b0;
    found       = 1'b0;
    gidx        = 0;
    idx         = 0;

    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(rr_q) + k) % NREQ;
      if (!found && ord_valid_i[idx]) begin
        found = 1'b1;
        gidx  = idx;
      end
    end

    case (state_q)
      S_IDLE: begin
        // config wins unless it took the previous grant and an order is waiting
        if (cfg_valid_i && !(last_cfg_q && |ord_valid_i)) begin
          cfg_ready_o = 1'b1;
          last_cfg_d  = 1'b1;
          is_cfg_d    = 1'b1;
          client_d    = cfg_client_i;
          max_d       = cfg_max_i;
          src_d       = 4'(NREQ);
          tmo_d       = '0;
          if (cfg_max_i < 16'd2) begin
            accept_d = 1'b0;
            err_d    = 1'b1;
            state_d  = S_RESP;
          end else begin
            state_d  = S_WR;
          end
        end else if (found) begin
          ord_ready_o[gidx] = 1'b1;
          last_cfg_d = 1'b0;
          is_cfg_d   = 1'b0;
          client_d   = ord_client_i[gidx*CLIENT_W +: CLIENT_W];
          qty_d      = ord_qty_i[gidx*16 +: 16];
          src_d      = 4'(gidx);
          rr_d       = RRW'((gidx + 1) % NREQ);
          tmo_d      = '0;
          if (ord_qty_i[gidx*16 +: 16] == 16'd0) begin
            accept_d = 1'b1;
            err_d    = 1'b0;
            state_d  = S_RESP;
          end else begin
            state_d  = S_RD;
          end
        end
      end
      S_RD: begin
        if (cpu_res_ready_i) begin
          rdata_d = cpu_res_data_i;
          state_d = S_CHECK;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          accept_d = 1'b0;
          err_d    = 1'b1;
          state_d  = S_RESP;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_CHECK: begin
        if (sum <= {1'b0, rdata_q[31:16]}) begin
          tmo_d   = '0;
          state_d = S_WR;
        end else begin
          accept_d  = 1'b0;
          err_d     = 1'b0;
          rej_cnt_d = rej_cnt_q + 1'b1;
          state_d   = S_RESP;
        end
      end
      S_WR: begin
        if (cpu_res_ready_i) begin
          accept_d = 1'b1;
          err_d    = 1'b0;
          if (!is_cfg_q) acc_cnt_d = acc_cnt_q + 1'b1;
          state_d  = S_RESP;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          accept_d = 1'b0;
          err_d    = 1'b1;
          state_d  = S_RESP;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_RESP: begin
        if (res_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // request fields come from latched state so they hold steady while valid is high
  assign cpu_req_valid_o = (state_q == S_RD) || (state_q == S_WR);
  assign cpu_req_rw_o    = (state_q == S_WR);
  assign cpu_req_addr_o  = cpu_req_valid_o ? 32'({client_q, 4'b0000}) : 32'h0;
  assign cpu_req_data_o  = (state_q != S_WR) ? 32'h0 :
                           is_cfg_q ? {max_q, 16'h0000} : {16'h0000, qty_q};

  assign res_valid_o  = (state_q == S_RESP);
  assign res_src_o    = src_q;
  assign res_accept_o = accept_q;
  assign res_err_o    = err_q;
  assign acc_cnt_o    = acc_cnt_q;
  assign rej_cnt_o    = rej_cnt_q;

endmodule

// File: tb/tb_risk_arbiter_upstream.sv
// Directed bench for risk_arbiter_upstream with a behavioural one-cycle-hit cache stub.
module tb_risk_arbiter_upstream;
  localparam int NREQ = 4;
  localparam int CW   = 10;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   ord_valid;
  logic [NREQ*CW-1:0] ord_client;
  logic [NREQ*16-1:0] ord_qty;
  logic [NREQ-1:0]   ord_ready;
  logic              cfg_valid;
  logic [CW-1:0]     cfg_client;
  logic [15:0]       cfg_max;
  logic              cfg_ready;
  logic              res_valid, res_ready, res_accept, res_err;
  logic [3:0]        res_src;
  logic              cpu_req_valid, cpu_req_rw;
  logic [31:0]       cpu_req_addr, cpu_req_data;
  logic              cres_ready = 1'b0;
  logic [31:0]       cres_data = 32'h0;
  logic [15:0]       acc_cnt, rej_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  // cache stub
  logic [31:0] mem [0:1023];
  logic        stall = 1'b0;
  logic        pl_en = 1'b0;
  logic [9:0]  pl_addr = '0;
  logic [31:0] pl_data = '0;
  int          vcnt = 0, rd_cnt = 0, wr_cnt = 0;
  logic [31:0] last_wdata = '0;

  always #5 clk = ~clk;

  risk_arbiter_upstream #(.NREQ(NREQ), .CLIENT_W(CW), .TIMEOUT(64)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .ord_valid_i(ord_valid), .ord_client_i(ord_client), .ord_qty_i(ord_qty),
    .ord_ready_o(ord_ready),
    .cfg_valid_i(cfg_valid), .cfg_client_i(cfg_client), .cfg_max_i(cfg_max),
    .cfg_ready_o(cfg_ready),
    .res_valid_o(res_valid), .res_ready_i(res_ready), .res_src_o(res_src),
    .res_accept_o(res_accept), .res_err_o(res_err),
    .cpu_req_valid_o(cpu_req_valid), .cpu_req_rw_o(cpu_req_rw),
    .cpu_req_addr_o(cpu_req_addr), .cpu_req_data_o(cpu_req_data),
    .cpu_res_ready_i(cres_ready), .cpu_res_data_i(cres_data),
    .acc_cnt_o(acc_cnt), .rej_cnt_o(rej_cnt)
  );

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    if (cpu_req_valid) vcnt <= vcnt + 1;
    if (cpu_req_valid && !cres_ready && !stall) begin
      cres_ready <= 1'b1;
      if (cpu_req_rw) begin
        wr_cnt     <= wr_cnt + 1;
        last_wdata <= cpu_req_data;
        if (cpu_req_data[31:16] > 16'd1) mem[cpu_req_addr[13:4]][31:16] <= cpu_req_data[31:16];
        else mem[cpu_req_addr[13:4]][15:0] <= mem[cpu_req_addr[13:4]][15:0] + cpu_req_data[15:0];
      end else begin
        rd_cnt    <= rd_cnt + 1;
        cres_data <= mem[cpu_req_addr[13:4]];
      end
    end else begin
      cres_ready <= 1'b0;
    end
  end

  task automatic preload(input int a, input logic [31:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = 10'(a); pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic send_order(input int s, input int cl, input int q, output int lat);
    lat = -1;
    @(negedge clk);
    ord_valid[s] = 1'b1;
    ord_client[s*CW +: CW] = CW'(cl);
    ord_qty[s*16 +: 16] = 16'(q);
    for (int i = 0; i < 20; i++) begin
      #1;
      if (ord_ready[s]) break;
      @(negedge clk);
    end
    @(negedge clk);
    ord_valid[s] = 1'b0;
    for (int n = 1; n < 200; n++) begin
      if (res_valid) begin lat = n; break; end
      @(negedge clk);
    end
  endtask

  task automatic send_cfg(input int cl, input int mx, output int lat);
    lat = -1;
    @(negedge clk);
    cfg_valid = 1'b1; cfg_client = CW'(cl); cfg_max = 16'(mx);
    for (int i = 0; i < 20; i++) begin
      #1;
      if (cfg_ready) break;
      @(negedge clk);
    end
    @(negedge clk);
    cfg_valid = 1'b0;
    for (int n = 1; n < 200; n++) begin
      if (res_valid) begin lat = n; break; end
      @(negedge clk);
    end
  endtask

  task automatic ack();
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ord_valid = '0; ord_client = '0; ord_qty = '0;
    cfg_valid = 1'b0; cfg_client = '0; cfg_max = '0; res_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (cpu_req_valid !== 1'b0 || cpu_req_rw !== 1'b0 || cpu_req_addr !== 32'h0 || cpu_req_data !== 32'h0) begin
      $display("FAIL reset_cpu_req: got v=%b rw=%b a=%h d=%h want all 0", cpu_req_valid, cpu_req_rw, cpu_req_addr, cpu_req_data); n_bad++; end
    n_cmp++; if (res_valid !== 1'b0 || res_accept !== 1'b0 || res_err !== 1'b0 || res_src !== 4'd0) begin
      $display("FAIL reset_res: got v=%b a=%b e=%b s=%0d want 0", res_valid, res_accept, res_err, res_src); n_bad++; end
    n_cmp++; if (acc_cnt !== 16'd0 || rej_cnt !== 16'd0) begin
      $display("FAIL reset_cnt: got acc=%0d rej=%0d want 0", acc_cnt, rej_cnt); n_bad++; end
    n_cmp++; if (ord_ready !== 4'b0 || cfg_ready !== 1'b0) begin
      $display("FAIL reset_ready: got ord=%b cfg=%b want 0", ord_ready, cfg_ready); n_bad++; end
  endtask

  task automatic test_accept();
    int lat, w0;
    preload(5, 32'h0064005A);
    preload(7, 32'hFFFFFFFF);
    w0 = wr_cnt;
    send_order(1, 5, 10, lat);
    n_cmp++; if (lat !== 6) begin $display("FAIL accept_lat: got %0d want 6", lat); n_bad++; end
    n_cmp++; if (res_accept !== 1'b1 || res_err !== 1'b0 || res_src !== 4'd1) begin
      $display("FAIL accept_res: got a=%b e=%b s=%0d want a=1 e=0 s=1", res_accept, res_err, res_src); n_bad++; end
    n_cmp++; if (wr_cnt - w0 !== 1 || last_wdata !== 32'h0000000A) begin
      $display("FAIL accept_wr: got n=%0d d=%h want n=1 d=0000000a", wr_cnt - w0, last_wdata); n_bad++; end
    ack();
    n_cmp++; if (mem[5] !== 32'h00640064) begin $display("FAIL accept_line: got %h want 00640064", mem[5]); n_bad++; end
    n_cmp++; if (acc_cnt !== 16'd1) begin $display("FAIL accept_acc_cnt: got %0d want 1", acc_cnt); n_bad++; end
  endtask

  task automatic test_reject();
    int lat, w0;
    w0 = wr_cnt;
    send_order(2, 5, 1, lat);
    n_cmp++; if (lat !== 4) begin $display("FAIL reject_lat: got %0d want 4", lat); n_bad++; end
    n_cmp++; if (res_accept !== 1'b0 || res_err !== 1'b0 || res_src !== 4'd2) begin
      $display("FAIL reject_res: got a=%b e=%b s=%0d want a=0 e=0 s=2", res_accept, res_err, res_src); n_bad++; end
    n_cmp++; if (wr_cnt - w0 !== 0) begin $display("FAIL reject_no_write: got %0d writes want 0", wr_cnt - w0); n_bad++; end
    ack();
    n_cmp++; if (rej_cnt !== 16'd1 || acc_cnt !== 16'd1) begin
      $display("FAIL reject_cnt: got rej=%0d acc=%0d want 1 1", rej_cnt, acc_cnt); n_bad++; end
  endtask

  task automatic test_nowrap();
    int lat;
    send_order(0, 7, 16'hFFFF, lat);
    n_cmp++; if (lat !== 4 || res_accept !== 1'b0 || res_err !== 1'b0) begin
      $display("FAIL nowrap_res: got lat=%0d a=%b e=%b want 4 0 0", lat, res_accept, res_err); n_bad++; end
    ack();
    n_cmp++; if (rej_cnt !== 16'd2 || mem[7] !== 32'hFFFFFFFF) begin
      $display("FAIL nowrap_state: got rej=%0d line=%h want 2 ffffffff", rej_cnt, mem[7]); n_bad++; end
  endtask

  task automatic test_qty_zero();
    int lat, a0;
    a0 = rd_cnt + wr_cnt;
    send_order(3, 5, 0, lat);
    n_cmp++; if (lat !== 1 || res_accept !== 1'b1 || res_err !== 1'b0 || res_src !== 4'd3) begin
      $display("FAIL qty0_res: got lat=%0d a=%b e=%b s=%0d want 1 1 0 3", lat, res_accept, res_err, res_src); n_bad++; end
    n_cmp++; if (rd_cnt + wr_cnt - a0 !== 0) begin $display("FAIL qty0_no_access: got %0d accesses want 0", rd_cnt + wr_cnt - a0); n_bad++; end
    ack();
  endtask

  task automatic test_cfg();
    int lat, a0;
    a0 = rd_cnt + wr_cnt;
    send_cfg(5, 1, lat);
    n_cmp++; if (lat !== 1 || res_accept !== 1'b0 || res_err !== 1'b1 || res_src !== 4'd4) begin
      $display("FAIL cfg_illegal: got lat=%0d a=%b e=%b s=%0d want 1 0 1 4", lat, res_accept, res_err, res_src); n_bad++; end
    n_cmp++; if (rd_cnt + wr_cnt - a0 !== 0) begin $display("FAIL cfg_illegal_access: got %0d want 0", rd_cnt + wr_cnt - a0); n_bad++; end
    ack();
    send_cfg(5, 200, lat);
    n_cmp++; if (lat !== 3 || res_accept !== 1'b1 || res_err !== 1'b0) begin
      $display("FAIL cfg_set_res: got lat=%0d a=%b e=%b want 3 1 0", lat, res_accept, res_err); n_bad++; end
    n_cmp++; if (last_wdata !== 32'h00C80000) begin $display("FAIL cfg_set_wdata: got %h want 00c80000", last_wdata); n_bad++; end
    ack();
    n_cmp++; if (mem[5] !== 32'h00C80064 || acc_cnt !== 16'd1) begin
      $display("FAIL cfg_set_line: got line=%h acc=%0d want 00c80064 1", mem[5], acc_cnt); n_bad++; end
  endtask

  task automatic test_round_robin();
    int seq[5];
    int k;
    int exp_rr[5] = '{0, 1, 2, 3, 0};
    int exp_mx[4] = '{4, 1, 4, 2};
    k = 0;
    for (int i = 0; i < NREQ; i++) seq[i] = -1;
    seq[4] = -1;
    res_ready = 1'b1;
    ord_client = '0; ord_qty = '0;
    @(negedge clk);
    ord_valid = 4'b1111;
    for (int c = 0; c < 60 && k < 5; c++) begin
      #1;
      for (int b = 0; b < NREQ; b++) if (ord_ready[b]) begin seq[k] = b; k++; end
      @(negedge clk);
    end
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (seq[i] !== exp_rr[i]) begin $display("FAIL rr_grant_%0d: got %0d want %0d", i, seq[i], exp_rr[i]); n_bad++; end
    end
    k = 0;
    for (int i = 0; i < 5; i++) seq[i] = -1;
    cfg_valid = 1'b1; cfg_client = 10'd3; cfg_max = 16'd1;
    for (int c = 0; c < 60 && k < 4; c++) begin
      #1;
      if (cfg_ready) begin seq[k] = 4; k++; end
      for (int b = 0; b < NREQ; b++) if (ord_ready[b]) begin seq[k] = b; k++; end
      @(negedge clk);
    end
    ord_valid = '0; cfg_valid = 1'b0;
    repeat (3) @(negedge clk);
    res_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (seq[i] !== exp_mx[i]) begin $display("FAIL mix_grant_%0d: got %0d want %0d", i, seq[i], exp_mx[i]); n_bad++; end
    end
  endtask

  task automatic test_timeout();
    int lat, v0;
    stall = 1'b1;
    v0 = vcnt;
    send_order(0, 5, 5, lat);
    n_cmp++; if (lat !== 65 || res_accept !== 1'b0 || res_err !== 1'b1) begin
      $display("FAIL timeout_res: got lat=%0d a=%b e=%b want 65 0 1", lat, res_accept, res_err); n_bad++; end
    n_cmp++; if (vcnt - v0 !== 64) begin $display("FAIL timeout_valid_cycles: got %0d want 64", vcnt - v0); n_bad++; end
    ack();
    stall = 1'b0;
    n_cmp++; if (acc_cnt !== 16'd1 || rej_cnt !== 16'd2) begin
      $display("FAIL timeout_cnt: got acc=%0d rej=%0d want 1 2", acc_cnt, rej_cnt); n_bad++; end
  endtask

  task automatic test_reset_mid();
    logic seen;
    stall = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b1; cfg_client = 10'd9; cfg_max = 16'd300;
    #1;
    n_cmp++; if (cfg_ready !== 1'b1) begin $display("FAIL rstmid_grant: got %b want 1", cfg_ready); n_bad++; end
    @(negedge clk);
    cfg_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (cpu_req_valid !== 1'b1 || cpu_req_rw !== 1'b1) begin
      $display("FAIL rstmid_in_wr: got v=%b rw=%b want 1 1", cpu_req_valid, cpu_req_rw); n_bad++; end
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++; if (cpu_req_valid !== 1'b0) begin $display("FAIL rstmid_valid_drop: got %b want 0", cpu_req_valid); n_bad++; end
    rst_n = 1'b1;
    stall = 1'b0;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (res_valid) seen = 1'b1;
    end
    n_cmp++; if (seen !== 1'b0) begin $display("FAIL rstmid_no_res: got res_valid seen=%b want 0", seen); n_bad++; end
    n_cmp++; if (acc_cnt !== 16'd0 || rej_cnt !== 16'd0) begin
      $display("FAIL rstmid_cnt: got acc=%0d rej=%0d want 0 0", acc_cnt, rej_cnt); n_bad++; end
  endtask

  initial begin
    test_reset();
    test_accept();
    test_reject();
    test_nowrap();
    test_qty_zero();
    test_cfg();
    test_round_robin();
    test_timeout();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
